seq_tx: RTL and testbench

SEQ_TX -- requirements
Module: seq_tx

---
 rtl/seq_tx_pkg.sv | 12 +
 rtl/seq_tx_shreg.sv | 36 +++
 rtl/seq_tx.sv | 105 ++++++++++
 tb/tb_seq_tx.sv | 139 +++++++++++++
 4 files changed

// File: rtl/seq_tx_pkg.sv
// Shared types and constants for the seq_tx serializer.
package seq_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_t;

  localparam int PAR_W = 1;

endpackage

// File: rtl/seq_tx_shreg.sv
// Loadable left-shift register with a down-counter and a last-bit flag.
module seq_tx_shreg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_msb,
  output logic             o_last
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] r_sh;
  logic [CW-1:0]    r_cnt;

  // Load wins over shift so a new frame always starts from a clean word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh  <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_sh  <= i_data;
      r_cnt <= CW'(WIDTH - 1);
    end else if (i_shift) begin
      r_sh  <= {r_sh[WIDTH-2:0], 1'b0};
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_msb  = r_sh[WIDTH-1];
  assign o_last = (r_cnt == '0);

endmodule

// File: rtl/seq_tx.sv
// MSB-first word serializer; define SEQ_TX_PARITY_EN to append an even-parity bit.
module seq_tx
  import seq_tx_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  input  logic             abort,
  output logic             x,
  output logic             x_valid,
  output logic             done
);

  state_t r_state;
  logic   w_accept;
  logic   w_shift;
  logic   w_msb;
  logic   w_last;

  assign data_ready = (r_state == IDLE);
  assign w_accept   = data_ready & data_valid & ~abort;
  assign w_shift    = (r_state == SHIFT);

  seq_tx_shreg #(
    .WIDTH (WIDTH)
  ) u_shreg (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_accept),
    .i_shift (w_shift),
    .i_data  (data_in),
    .o_msb   (w_msb),
    .o_last  (w_last)
  );

`ifdef SEQ_TX_PARITY_EN
  logic [PAR_W-1:0] r_par;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_par <= '0;
    end else if (w_accept) begin
      r_par <= ^data_in;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_accept) r_state <= SHIFT;
        SHIFT: begin
          if (abort) begin
            r_state <= IDLE;
          end else if (w_last) begin
`ifdef SEQ_TX_PARITY_EN
            r_state <= PAR;
`else
            r_state <= IDLE;
`endif
          end
        end
`ifdef SEQ_TX_PARITY_EN
        PAR:     r_state <= IDLE;
`endif
        default: r_state <= IDLE;
      endcase
    end
  end

  // done is Mealy on the final frame bit; an abort in that same cycle suppresses it.
  always_comb begin
    x       = 1'b0;
    x_valid = 1'b0;
    done    = 1'b0;
    case (r_state)
      SHIFT: begin
        x       = w_msb;
        x_valid = 1'b1;
`ifndef SEQ_TX_PARITY_EN
        done    = w_last & ~abort;
`endif
      end
`ifdef SEQ_TX_PARITY_EN
      PAR: begin
        x       = r_par[0];
        x_valid = 1'b1;
        done    = ~abort;
      end
`endif
      default: begin
        x       = 1'b0;
        x_valid = 1'b0;
        done    = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_seq_tx.sv
// Directed scoreboard bench for seq_tx: expected bits are queued on acceptance and popped per output cycle.
module tb_seq_tx;

  localparam int W = 8;
`ifdef SEQ_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         data_valid = 1'b0;
  logic         abort = 1'b0;
  logic         data_ready;
  logic         x;
  logic         x_valid;
  logic         done;

  int   checks = 0;
  int   failures = 0;
  logic q[$];

  always #5 clk = ~clk;

  seq_tx #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .abort      (abort),
    .x          (x),
    .x_valid    (x_valid),
    .done       (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [W-1:0] d);
    for (int i = W - 1; i >= 0; i--) q.push_back(d[i]);
`ifdef SEQ_TX_PARITY_EN
    q.push_back(^d);
`endif
  endtask

  task automatic sample(input string tag);
    if (q.size() > 0) begin
      chk({tag, ".x"},       32'(x),          32'(q[0]));
      chk({tag, ".x_valid"}, 32'(x_valid),    32'd1);
      chk({tag, ".done"},    32'(done),       32'(q.size() == 1 && !abort));
      chk({tag, ".ready"},   32'(data_ready), 32'd0);
    end else begin
      chk({tag, ".x"},       32'(x),          32'd0);
      chk({tag, ".x_valid"}, 32'(x_valid),    32'd0);
      chk({tag, ".done"},    32'(done),       32'd0);
      chk({tag, ".ready"},   32'(data_ready), 32'd1);
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    if (rst_n) begin
      if (q.size() > 0) begin
        if (abort) q.delete();
        else void'(q.pop_front());
      end else if (data_valid && !abort) begin
        push_word(data_in);
      end
    end
    @(negedge clk);
    sample(tag);
  endtask

  initial begin
    // Reset held for three cycles
    #1 sample("rst0");
    repeat (3) tick("rst");
    rst_n = 1'b1;

    // Basic frame, offered on the first edge after reset release
    data_in = 8'hA5; data_valid = 1'b1;
    tick("a5");
    data_valid = 1'b0;
    repeat (W + PB + 1) tick("a5");

    // Back-to-back: data_in changes mid-frame must not affect the frame
    data_in = 8'hFF; data_valid = 1'b1;
    tick("ff");
    data_in = 8'h00;
    repeat (W + PB - 1) tick("ff");
    tick("gap");
    tick("zz");
    data_valid = 1'b0;
    repeat (W + PB) tick("zz");

    // Abort raised while the 4th bit is on x
    data_in = 8'h3C; data_valid = 1'b1;
    tick("3c");
    data_valid = 1'b0;
    repeat (3) tick("3c");
    abort = 1'b1;
    tick("abort");
    data_in = 8'h81; data_valid = 1'b1;
    tick("abort_prio");
    abort = 1'b0;
    tick("81");
    data_valid = 1'b0;
    repeat (W + PB + 1) tick("81");

    // Asynchronous reset during bit 5
    data_in = 8'h5A; data_valid = 1'b1;
    tick("5a");
    data_valid = 1'b0;
    repeat (4) tick("5a");
    #2 rst_n = 1'b0;
    q.delete();
    #1 sample("arst");
    #1 rst_n = 1'b1;
    repeat (W + PB + 1) tick("post_arst");

    // Parity-sensitive word (three ones)
    data_in = 8'h07; data_valid = 1'b1;
    tick("07");
    data_valid = 1'b0;
    repeat (W + PB + 1) tick("07");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
